gng_lzd_pipe: RTL and testbench
===============================

Name: gng_lzd_pipe

Overview:
Parametrised, pipelined leading-zero detector for the logarithm unit of the Gaussian noise generator datapath. It generalises the fixed 48-bit combinational detector to any input width, with configurable register spacing in the reduction tree. It adds valid/ready flow control, an all-zero flag, a sideband tag, and an optional normalised (left-shifted) data output.

Parameters:
DATA_W, 48, input width in bits (2..256)
REG_STRIDE, 2, tree levels between pipeline registers (1..LVL)
TAG_W, 1, width of sideband tag carried alongside data
(derived) W_PAD = next power of two >= DATA_W; LVL = log2(W_PAD); CNT_W = ceil(log2(DATA_W+1))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block accepts input this cycle
data_in  in  DATA_W  word to analyse, MSB first
tag_in  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
cnt_out  out  CNT_W  leading-zero count
zero_out  out  1  data_in was all zeros
tag_out  out  TAG_W  tag matching the result
norm_out  out  DATA_W  normalised data; present only with GNG_LZD_NORM_EN

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Padding: d = {data_in, (W_PAD-DATA_W) ones}. An all-zero input yields cnt_out = DATA_W and zero_out = 1; otherwise zero_out = 0 and cnt_out is in 0..DATA_W-1.
- Tree levels:
  - Level 1 forms per-pair (p, v) from d.
  - Each later level k merges pairs: p = {~v_hi, v_hi ? p_hi : p_lo}, v = v_hi | v_lo.
- Registers:
  - An input register captures data and tag on handshake.
  - A pipeline register follows every REG_STRIDE levels, and always after level LVL.
- Latency: L = 1 + ceil(LVL/REG_STRIDE) cycles from the accept edge to out_valid. Default: LVL=6, L=4.
- Flow control:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stall is high, every stage and its valid bit hold. Otherwise all stages advance one position.
  - Bubbles are not compressed.
  - Transfer occurs on valid&ready at each end. Order is strictly preserved.
- Stable output: while out_valid=1 and out_ready=0, cnt_out, zero_out, tag_out and norm_out are stable.
- Reset values: out_valid=0, cnt_out=0, zero_out=0, tag_out=0, norm_out=0, all internal valids 0. Assertion is asynchronous.
  - Reset mid-stream discards all in-flight words.
  - in_ready is 1 while rst is high (no stall is possible).
- in_valid=0 inserts a bubble; data_in is ignored.
- Simultaneous accept and emit in one cycle is supported at full rate (1 word/cycle).

Optional Feature:
GNG_LZD_NORM_EN:
- Defined:
  - An extra stage after the tree computes norm_out = data_in << cnt_out, truncated to DATA_W. All-zero input gives 0.
  - Data is carried alongside the tree through the pipeline.
  - Latency becomes L+1.
- Undefined: no norm_out port, no data carried through the pipeline, latency L.

Decomposition:
- Package gng_lzd_pkg:
  - clog2 function
  - functions computing W_PAD, LVL, CNT_W, and latency for a given DATA_W/REG_STRIDE/NORM setting
- Sub-module gng_lzd_merge: one parametrised tree node, combinational.
  - Input: two (p, v) pairs of width k-1.
  - Output: one (p, v) of width k.
  - Instantiated by generate loops per level.

Test Plan:
- Defaults, out_ready=1: data_in=48'h8000_0000_0000 -> 4 cycles later cnt_out=0, zero_out=0.
- Single-bit and zero inputs:
  - data_in=48'h0000_0000_0001 -> cnt_out=47.
  - data_in=0 -> cnt_out=48, zero_out=1.
- Streaming: 256 random words, one per cycle, tag_in = index mod 2 -> out_valid continuous after 4 cycles; counts match a reference model; tags in order.
- Backpressure:
  - Pipeline full, out_ready held 0 for 3 cycles -> in_ready=0, outputs stable, no loss or duplication.
  - After release -> resumes at 1 word/cycle.
- Reset mid-stream: rst pulsed with 3 words in flight -> out_valid drops immediately; no stale word emerges after release.
- With GNG_LZD_NORM_EN: data_in=48'h0000_0123_4567 -> 5 cycles later cnt_out=23, norm_out=48'h91A2_B380_0000.
- Parameter sweep: DATA_W=64 -> all-zero gives cnt_out=64 (7 bits).
- Parameter sweep: REG_STRIDE=1 -> latency 7.

Source files
------------

// File: rtl/gng_lzd_pkg.sv
// Sizing helpers shared by the pipelined leading-zero detector.
// GNG_LZD_NORM_EN (defined in gng_lzd_pipe) adds a normalise stage; latency_f takes it as an argument.
package gng_lzd_pkg;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int wpad_f(input int dw);
    return 1 << clog2_f(dw);
  endfunction

  function automatic int lvl_f(input int dw);
    return clog2_f(dw);
  endfunction

  function automatic int cntw_f(input int dw);
    return clog2_f(dw + 1);
  endfunction

  // Input register, one register per REG_STRIDE tree levels, optional normalise stage.
  function automatic int latency_f(input int dw, input int stride, input bit norm);
    return 1 + (lvl_f(dw) + stride - 1) / stride + (norm ? 1 : 0);
  endfunction

endpackage

// File: rtl/gng_lzd_merge.sv
// One reduction-tree node: combines the (p, v) of two adjacent halves into the
// (p, v) of the whole; p is the leading-zero count, valid only while v is set.
module gng_lzd_merge #(
  parameter int PW = 1
) (
  input  logic          i_v_hi,
  input  logic [PW-1:0] i_p_hi,
  input  logic          i_v_lo,
  input  logic [PW-1:0] i_p_lo,
  output logic          o_v,
  output logic [PW:0]   o_p
);

  assign o_v = i_v_hi | i_v_lo;
  assign o_p = {~i_v_hi, (i_v_hi ? i_p_hi : i_p_lo)};

endmodule

// File: rtl/gng_lzd_pipe.sv
// Pipelined leading-zero detector with valid/ready flow control and tag sideband.
// Defining GNG_LZD_NORM_EN adds norm_out (data left-justified) and one extra stage.
module gng_lzd_pipe
  import gng_lzd_pkg::*;
#(
  parameter int DATA_W     = 48,
  parameter int REG_STRIDE = 2,
  parameter int TAG_W      = 1,
  localparam int CNT_W     = cntw_f(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              zero_out,
  output logic [TAG_W-1:0]  tag_out
`ifdef GNG_LZD_NORM_EN
  ,
  output logic [DATA_W-1:0] norm_out
`endif
);

  localparam int W_PAD = wpad_f(DATA_W);
  localparam int LVL   = lvl_f(DATA_W);
  localparam int R     = (LVL + REG_STRIDE - 1) / REG_STRIDE;
`ifdef GNG_LZD_NORM_EN
  localparam int DR = R;
`else
  localparam int DR = 0;
`endif

  // Handshake: a word moves across either end on a clock edge where valid and
  // ready are both high. The whole pipe freezes only when the output word is
  // being refused, so in_ready never depends on in_valid.
  logic              w_stall;
  logic              w_en;
  logic [R:0]        r_vld;
  logic [TAG_W-1:0]  r_tag [0:R];
  logic [DATA_W-1:0] r_dat [0:DR];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_zero;
  logic [W_PAD-1:0]  w_d;
  logic              w_top_v;
  logic [LVL-1:0]    w_top_p;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_zero;

  assign w_stall  = out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = ~w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
      for (int r = 0; r <= R; r++) r_tag[r] <= '0;
      for (int r = 0; r <= DR; r++) r_dat[r] <= '0;
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_tag[0] <= tag_in;
        r_dat[0] <= data_in;
      end
      for (int r = 1; r <= R; r++) begin
        r_vld[r] <= r_vld[r-1];
        r_tag[r] <= r_tag[r-1];
      end
      for (int r = 1; r <= DR; r++) r_dat[r] <= r_dat[r-1];
      r_cnt  <= w_cnt;
      r_zero <= w_zero;
    end
  end

  // Trailing ones guarantee the padded word is never all-zero unless DATA_W == W_PAD.
  if (W_PAD > DATA_W) begin : gen_pad
    assign w_d = {r_dat[0], {(W_PAD - DATA_W){1'b1}}};
  end else begin : gen_nopad
    assign w_d = r_dat[0];
  end

  // Level k holds W_PAD>>k nodes packed as {v, p[k-1:0]}, node j covering d[j*2^k +: 2^k].
  for (genvar k = 1; k <= LVL; k++) begin : gen_lvl
    localparam int NB = W_PAD >> k;
    localparam int LB = NB * (k + 1);
    logic [LB-1:0] w_comb;
    logic [LB-1:0] w_q;

    if (k == 1) begin : gen_first
      for (genvar j = 0; j < NB; j++) begin : gen_node
        assign w_comb[2*j +: 2] = {w_d[2*j+1] | w_d[2*j], ~w_d[2*j+1]};
      end
    end else begin : gen_merge
      for (genvar j = 0; j < NB; j++) begin : gen_node
        gng_lzd_merge #(.PW(k - 1)) u_merge (
          .i_v_hi (gen_lvl[k-1].w_q[(2*j+1)*k + k - 1]),
          .i_p_hi (gen_lvl[k-1].w_q[(2*j+1)*k +: k - 1]),
          .i_v_lo (gen_lvl[k-1].w_q[(2*j)*k + k - 1]),
          .i_p_lo (gen_lvl[k-1].w_q[(2*j)*k +: k - 1]),
          .o_v    (w_comb[j*(k+1) + k]),
          .o_p    (w_comb[j*(k+1) +: k])
        );
      end
    end

    if ((k % REG_STRIDE == 0) && (k < LVL)) begin : gen_reg
      logic [LB-1:0] r_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else if (w_en) r_q <= w_comb;
      end
      assign w_q = r_q;
    end else begin : gen_wire
      assign w_q = w_comb;
    end
  end

  assign w_top_v = gen_lvl[LVL].w_q[LVL];
  assign w_top_p = gen_lvl[LVL].w_q[LVL-1:0];
  // Root v clear only happens for an unpadded all-zero word; padded ones stop the count at DATA_W.
  assign w_cnt   = w_top_v ? CNT_W'(w_top_p) : CNT_W'(DATA_W);
  assign w_zero  = (w_cnt == CNT_W'(DATA_W));

`ifdef GNG_LZD_NORM_EN
  logic              r_vld_n;
  logic [TAG_W-1:0]  r_tag_n;
  logic [CNT_W-1:0]  r_cnt_n;
  logic              r_zero_n;
  logic [DATA_W-1:0] r_norm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_n  <= 1'b0;
      r_tag_n  <= '0;
      r_cnt_n  <= '0;
      r_zero_n <= 1'b0;
      r_norm   <= '0;
    end else if (w_en) begin
      r_vld_n  <= r_vld[R];
      r_tag_n  <= r_tag[R];
      r_cnt_n  <= r_cnt;
      r_zero_n <= r_zero;
      r_norm   <= r_dat[R] << r_cnt;
    end
  end

  assign out_valid = r_vld_n;
  assign cnt_out   = r_cnt_n;
  assign zero_out  = r_zero_n;
  assign tag_out   = r_tag_n;
  assign norm_out  = r_norm;
`else
  assign out_valid = r_vld[R];
  assign cnt_out   = r_cnt;
  assign zero_out  = r_zero;
  assign tag_out   = r_tag[R];
`endif

endmodule

// File: tb/tb_gng_lzd_pipe.sv
// Self-checking bench for gng_lzd_pipe: default instance with scoreboard plus a
// DATA_W=64 / REG_STRIDE=1 instance driven directly. Honours GNG_LZD_NORM_EN.
module tb_gng_lzd_pipe;

  localparam int DATA_W = 48;
  localparam int TAG_W  = 1;
  localparam int CNT_W  = 6;
`ifdef GNG_LZD_NORM_EN
  localparam int NORM = 1;
`else
  localparam int NORM = 0;
`endif
  localparam int LAT   = 4 + NORM;
  localparam int LAT64 = 7 + NORM;
  localparam int EW    = DATA_W + TAG_W + 1 + CNT_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] data_in = '0;
  logic [TAG_W-1:0]  tag_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  cnt_out;
  logic              zero_out;
  logic [TAG_W-1:0]  tag_out;
  logic [DATA_W-1:0] norm_out;

  logic        i64_valid = 1'b0;
  logic        i64_ready;
  logic [63:0] i64_data = '0;
  logic [2:0]  i64_tag = '0;
  logic        o64_valid;
  logic        o64_ready = 1'b1;
  logic [6:0]  o64_cnt;
  logic        o64_zero;
  logic [2:0]  o64_tag;
  logic [63:0] o64_norm;

`ifndef GNG_LZD_NORM_EN
  assign norm_out = '0;
  assign o64_norm = '0;
`endif

  gng_lzd_pipe #(.DATA_W(DATA_W), .REG_STRIDE(2), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt_out(cnt_out), .zero_out(zero_out), .tag_out(tag_out)
`ifdef GNG_LZD_NORM_EN
    , .norm_out(norm_out)
`endif
  );

  gng_lzd_pipe #(.DATA_W(64), .REG_STRIDE(1), .TAG_W(3)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(i64_valid), .in_ready(i64_ready), .data_in(i64_data), .tag_in(i64_tag),
    .out_valid(o64_valid), .out_ready(o64_ready),
    .cnt_out(o64_cnt), .zero_out(o64_zero), .tag_out(o64_tag)
`ifdef GNG_LZD_NORM_EN
    , .norm_out(o64_norm)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_emit = 0;
  int first_emit_cyc = 0;
  int last_emit_cyc = 0;
  bit track_first = 1'b0;

  logic [EW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: scan from the MSB down, counting zeros until the first one.
  function automatic int ref_lz(input logic [255:0] d, input int w);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i]) seen = 1'b1;
      if (!seen) n++;
    end
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DATA_W-1:0] >> $urandom_range(0, DATA_W);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard / monitor
  bit                prev_stall = 1'b0;
  logic [CNT_W-1:0]  prev_cnt;
  logic              prev_zero;
  logic [TAG_W-1:0]  prev_tag;
  logic [DATA_W-1:0] prev_norm;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", 64'(out_valid), 64'd1);
        check_val("hold_cnt", 64'(cnt_out), 64'(prev_cnt));
        check_val("hold_zero", 64'(zero_out), 64'(prev_zero));
        check_val("hold_tag", 64'(tag_out), 64'(prev_tag));
        if (NORM != 0) check_val("hold_norm", 64'(norm_out), 64'(prev_norm));
      end
      if (in_valid && in_ready) begin
        int lz;
        logic [DATA_W-1:0] nrm;
        lz  = ref_lz(256'(data_in), DATA_W);
        nrm = data_in << lz;
        exp_q.push_back({nrm, tag_in, (lz == DATA_W), CNT_W'(lz)});
      end
      if (out_valid && out_ready) begin
        logic [EW-1:0] e;
        n_emit++;
        if (track_first) begin
          first_emit_cyc = cyc;
          track_first = 1'b0;
        end
        last_emit_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("cnt", 64'(cnt_out), 64'(e[CNT_W-1:0]));
          check_val("zero", 64'(zero_out), 64'(e[CNT_W]));
          check_val("tag", 64'(tag_out), 64'(e[CNT_W+1 +: TAG_W]));
          if (NORM != 0) check_val("norm", 64'(norm_out), 64'(e[EW-1 -: DATA_W]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_cnt   = cnt_out;
      prev_zero  = zero_out;
      prev_tag   = tag_out;
      prev_norm  = norm_out;
    end
  end

  // driver tasks (all called at 1ns after a rising edge)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    data_in  = d;
    tag_in   = t;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) check_val("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_word(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t, input string name);
    int n;
    send_word(d, t);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_val(name, 64'(n), 64'(LAT));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_val(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run64(input logic [63:0] d, input logic [2:0] t, input string name);
    int n;
    int lz;
    logic [63:0] nrm;
    lz  = ref_lz(256'(d), 64);
    nrm = d << lz;
    i64_valid = 1'b1;
    i64_data  = d;
    i64_tag   = t;
    @(posedge clk);
    #1;
    i64_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!o64_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_val({name, "_lat"}, 64'(n), 64'(LAT64));
    check_val({name, "_cnt"}, 64'(o64_cnt), 64'(lz));
    check_val({name, "_zero"}, 64'(o64_zero), 64'(lz == 64));
    check_val({name, "_tag"}, 64'(o64_tag), 64'(t));
    if (NORM != 0) check_val({name, "_norm"}, o64_norm, nrm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int emit_base;
    bit rnd_done;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_cnt", 64'(cnt_out), 64'd0);
    check_val("rst_zero", 64'(zero_out), 64'd0);
    check_val("rst_tag", 64'(tag_out), 64'd0);
    check_val("rst_norm", 64'(norm_out), 64'd0);
    check_val("rst_out_valid64", 64'(o64_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // directed words with latency
    lat_word(48'h8000_0000_0000, 1'b1, "lat_msb");
    idle(6);
    lat_word(48'h0000_0000_0001, 1'b0, "lat_lsb");
    idle(6);
    lat_word(48'h0, 1'b1, "lat_zero");
    idle(6);
    lat_word(48'h0000_0123_4567, 1'b0, "lat_mid");
    idle(6);
    drain("drain_directed");

    // parameter sweep instance
    run64(64'h0, 3'd5, "w64_zero");
    run64(64'h1, 3'd2, "w64_lsb");
    for (int i = 0; i < 4; i++) run64({$urandom, $urandom} >> $urandom_range(0, 63), 3'(i), "w64_rnd");

    // back-to-back streaming
    emit_base = n_emit;
    track_first = 1'b1;
    for (int i = 0; i < 256; i++) send_word(rnd_word(), 1'(i % 2));
    drain("drain_stream");
    check_val("stream_count", 64'(n_emit - emit_base), 64'd256);
    check_val("stream_contig", 64'(last_emit_cyc - first_emit_cyc), 64'd255);

    // backpressure on a full pipe
    fork
      begin
        for (int i = 0; i < 20; i++) send_word(rnd_word(), 1'(i % 2));
      end
      begin
        int g;
        g = 0;
        while (!out_valid && g < 40) begin
          @(posedge clk);
          #1;
          g++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_val("bp_in_ready", 64'(in_ready), 64'd0);
          check_val("bp_out_valid", 64'(out_valid), 64'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        emit_base = n_emit;
        repeat (5) @(posedge clk);
        #1;
        check_val("bp_resume_rate", 64'(n_emit - emit_base), 64'd5);
      end
    join
    drain("drain_bp");

    // random bubbles and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send_word(rnd_word(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    // reset with words in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_word(rnd_word(), 1'(i % 2));
    begin
      int g;
      g = 0;
      while (!out_valid && g < 40) begin
        @(posedge clk);
        #1;
        g++;
      end
    end
    check_val("pre_rst_valid", 64'(out_valid), 64'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_val("rst_async_valid", 64'(out_valid), 64'd0);
    check_val("rst_async_ready", 64'(in_ready), 64'd1);
    check_val("rst_async_cnt", 64'(cnt_out), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    emit_base = n_emit;
    idle(12);
    check_val("post_rst_no_stale", 64'(n_emit - emit_base), 64'd0);

    // pipe still works after reset
    lat_word(48'h0000_0100_0000, 1'b1, "lat_after_rst");
    idle(6);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
